project5_sequencer: RTL and testbench

Operand-entry and execution sequencer for the project 5 calculator, located between the board inputs (KEY[1], SW) and the function unit.
- Synchronises and edge-detects the Enter key.
- Steps through opcode, operand A and operand B entry.
- Issues a one-cycle execute strobe to the function unit.
- For multiply (opcode 0xC), issues one shift-add step per further Enter press until the product is complete.

---
 rtl/project5_pkg.sv | 50 +++++
 rtl/key_edge_sync.sv | 38 +++
 rtl/project5_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_project5_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/project5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : project5_pkg
// Description : Shared constants and types for the project 5 calculator
//               sequencer: state encoding, opcode map, multiply step count
//               and the unary-opcode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package project5_pkg;

  // FSM state encoding (also shown on the debug LEDs)
  localparam logic [2:0] ST_LOAD_OP = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_MULT    = 3'd4;

  typedef enum logic [2:0] {
    LOAD_OP = ST_LOAD_OP,
    LOAD_A  = ST_LOAD_A,
    LOAD_B  = ST_LOAD_B,
    EXEC    = ST_EXEC,
    MULT    = ST_MULT
  } state_t;

  // Function-unit opcode map
  localparam logic [3:0] AND_ID = 4'd0;
  localparam logic [3:0] NAND   = 4'd1;
  localparam logic [3:0] NOR    = 4'd2;
  localparam logic [3:0] XOR    = 4'd3;
  localparam logic [3:0] ONES   = 4'd4;
  localparam logic [3:0] ADD    = 4'd5;
  localparam logic [3:0] SUB    = 4'd6;
  localparam logic [3:0] NEG    = 4'd7;
  localparam logic [3:0] ASL    = 4'd8;
  localparam logic [3:0] ASR    = 4'd9;
  localparam logic [3:0] ROL    = 4'd10;
  localparam logic [3:0] ROR    = 4'd11;
  localparam logic [3:0] MUL    = 4'd12;

  // Number of Enter-driven shift-add steps for an 8-bit multiply
  localparam int unsigned DEFAULT_MULT_STEPS = 8;

  // Unary ops take only operand A; operand B is forced to zero for them
  function automatic logic is_unary(input logic [3:0] op);
    return (op == ONES) || (op == NEG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_sync
// Description : Two-flop synchroniser for an active-low push button plus a
//               third flop for edge compare. o_press is high for one cycle
//               after each synchronised falling edge (key press).
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchroniser chain and edge-compare flop; reset to the released level
  // so that a reset never looks like a key press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Falling edge: synchronised level is low, previous level was high
  assign o_press = r_prev & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/project5_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : project5_sequencer
// Description : Operand-entry and execution sequencer for the project 5
//               calculator. Steps through opcode / A / B entry on Enter,
//               issues the execute strobe, and paces the stepped multiply
//               with one shift-add step per further Enter press.
// Revision    : 1.0 - initial release
// ============================================================================
module project5_sequencer
  import project5_pkg::*;
#(
  parameter logic [3:0]  MULT_OP    = 4'hC,
  parameter int unsigned MULT_STEPS = DEFAULT_MULT_STEPS,
  parameter logic [3:0]  MAX_OP     = 4'hC
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter_n,
  input  logic [7:0] sw,
  output logic [3:0] op_reg,
  output logic [7:0] opa_reg,
  output logic [7:0] opb_reg,
  output logic       exec_pulse,
  output logic       mult_init,
  output logic       mult_step,
  output logic [3:0] step_cnt,
  output logic [2:0] state,
  output logic       op_err
);

  localparam logic [3:0] STEPS_LAST = 4'(MULT_STEPS);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_key_press;
  logic       r_enter;
  logic [3:0] r_op;
  logic [7:0] r_opa;
  logic [7:0] r_opb;
  logic       r_exec;
  logic       r_init;
  logic       r_step;
  logic [3:0] r_step_cnt;
  logic       r_op_err;

  logic       w_load_op;
  logic       w_load_a;
  logic       w_load_b;
  logic       w_zero_b;
  logic       w_err_set;
  logic       w_err_clr;
  logic       w_step_clr;
  logic       w_step_inc;
  logic       w_exec_d;
  logic       w_init_d;
  logic       w_step_d;

  key_edge_sync u_enter_sync (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_key_n (enter_n),
    .o_press (w_key_press)
  );

  // Retime the press pulse so the FSM sees it one cycle later; the strobe
  // logic below looks at the unretimed pulse to line mult_step up with it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_enter <= 1'b0;
    else       r_enter <= w_key_press;
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= LOAD_OP;
    else       r_state <= w_state_next;
  end

  // Next-state decode and datapath load enables
  always_comb begin
    w_state_next = r_state;
    w_load_op    = 1'b0;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_zero_b     = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    w_step_clr   = 1'b0;
    w_step_inc   = 1'b0;
    case (r_state)
      LOAD_OP: begin
        if (r_enter) begin
          if (sw[3:0] <= MAX_OP) begin
            w_load_op    = 1'b1;
            w_err_clr    = 1'b1;
            w_state_next = LOAD_A;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (r_enter) begin
          w_load_a = 1'b1;
          if (is_unary(r_op)) begin
            w_zero_b     = 1'b1;
            w_state_next = EXEC;
          end else begin
            w_state_next = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (r_enter) begin
          w_load_b     = 1'b1;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        // Single-cycle state; a press landing here is intentionally dropped
        if (r_op == MULT_OP) begin
          w_step_clr   = 1'b1;
          w_state_next = MULT;
        end else begin
          w_state_next = LOAD_OP;
        end
      end
      MULT: begin
        if (r_enter) begin
          w_step_inc = 1'b1;
          if (r_step_cnt >= STEPS_LAST - 4'd1) begin
            w_state_next = LOAD_OP;
          end
        end
      end
      default: begin
        w_state_next = LOAD_OP;
      end
    endcase
  end

  // Strobes are registered from the next-state decode so each one is high
  // exactly while the FSM sits in (or is about to act in) the matching state.
  assign w_exec_d = (w_state_next == EXEC);
  assign w_init_d = w_exec_d && (r_op == MULT_OP);
  assign w_step_d = w_key_press && (w_state_next == MULT);

  // Operand, opcode, step counter, error flag and strobe registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_op       <= 4'd0;
      r_opa      <= 8'd0;
      r_opb      <= 8'd0;
      r_step_cnt <= 4'd0;
      r_op_err   <= 1'b0;
      r_exec     <= 1'b0;
      r_init     <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      if (w_load_op) r_op  <= sw[3:0];
      if (w_load_a)  r_opa <= sw;
      if (w_zero_b)  r_opb <= 8'd0;
      else if (w_load_b) r_opb <= sw;
      if (w_step_clr) r_step_cnt <= 4'd0;
      else if (w_step_inc && (r_step_cnt < STEPS_LAST)) r_step_cnt <= r_step_cnt + 4'd1;
      if (w_err_set)      r_op_err <= 1'b1;
      else if (w_err_clr) r_op_err <= 1'b0;
      r_exec <= w_exec_d;
      r_init <= w_init_d;
      r_step <= w_step_d;
    end
  end

  assign op_reg     = r_op;
  assign opa_reg    = r_opa;
  assign opb_reg    = r_opb;
  assign exec_pulse = r_exec;
  assign mult_init  = r_init;
  assign mult_step  = r_step;
  assign step_cnt   = r_step_cnt;
  assign state      = r_state;
  assign op_err     = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_project5_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_project5_sequencer
// Description : Directed self-checking bench for project5_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_project5_sequencer;

  logic       CLOCK_50;
  logic       reset;
  logic       enter_n;
  logic [7:0] sw;
  logic [3:0] op_reg;
  logic [7:0] opa_reg;
  logic [7:0] opb_reg;
  logic       exec_pulse;
  logic       mult_init;
  logic       mult_step;
  logic [3:0] step_cnt;
  logic [2:0] state;
  logic       op_err;

  int checks = 0;
  int errors = 0;

  // Strobe counters and timing-relationship violations seen by the monitor
  int n_exec = 0;
  int n_init = 0;
  int n_step = 0;
  int n_bad  = 0;
  logic       step_pending = 1'b0;
  logic [3:0] step_expect  = 4'd0;

  int base_exec;
  int base_init;
  int base_step;

  project5_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enter_n    (enter_n),
    .sw         (sw),
    .op_reg     (op_reg),
    .opa_reg    (opa_reg),
    .opb_reg    (opb_reg),
    .exec_pulse (exec_pulse),
    .mult_init  (mult_init),
    .mult_step  (mult_step),
    .step_cnt   (step_cnt),
    .state      (state),
    .op_err     (op_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Count strobes and check their relationships, sampling on the falling edge
  always @(negedge CLOCK_50) begin
    if (exec_pulse) n_exec++;
    if (mult_init)  n_init++;
    if (mult_step)  n_step++;
    if (mult_init && !exec_pulse) n_bad++;
    if (exec_pulse && state != 3'd3) n_bad++;
    if (step_pending && step_cnt != step_expect) n_bad++;
    step_pending = mult_step;
    step_expect  = step_cnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One key press: low for low_cycles clocks, then a four-clock gap
  task automatic press(input logic [7:0] val, input int low_cycles);
    @(negedge CLOCK_50);
    sw      = val;
    enter_n = 1'b0;
    repeat (low_cycles) @(negedge CLOCK_50);
    enter_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic snap();
    base_exec = n_exec;
    base_init = n_init;
    base_step = n_step;
  endtask

  initial begin
    reset   = 1'b1;
    enter_n = 1'b1;
    sw      = 8'h00;
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Reset state
    check("rst_state",    32'(state),      32'd0);
    check("rst_op",       32'(op_reg),     32'd0);
    check("rst_opa",      32'(opa_reg),    32'd0);
    check("rst_opb",      32'(opb_reg),    32'd0);
    check("rst_exec",     32'(exec_pulse), 32'd0);
    check("rst_init",     32'(mult_init),  32'd0);
    check("rst_step",     32'(mult_step),  32'd0);
    check("rst_step_cnt", 32'(step_cnt),   32'd0);
    check("rst_op_err",   32'(op_err),     32'd0);
    repeat (4) @(negedge CLOCK_50);
    check("idle_state",   32'(state),      32'd0);
    check("idle_strobes", 32'(n_exec + n_step + n_init), 32'd0);

    // Binary op with capture-latency check on the opcode press
    snap();
    @(negedge CLOCK_50);
    sw      = 8'h01;
    enter_n = 1'b0;           // sampled at the next rising edge (k)
    @(negedge CLOCK_50);      // after k
    @(negedge CLOCK_50);      // after k+1
    enter_n = 1'b1;
    @(negedge CLOCK_50);      // after k+2
    check("lat_k2_state", 32'(state),  32'd0);
    @(negedge CLOCK_50);      // after k+3
    check("lat_k3_state", 32'(state),  32'd1);
    check("lat_k3_op",    32'(op_reg), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    press(8'h94, 2);
    check("bin_state_b",  32'(state),  32'd2);
    press(8'hA6, 2);
    check("bin_op",       32'(op_reg),  32'h1);
    check("bin_opa",      32'(opa_reg), 32'h94);
    check("bin_opb",      32'(opb_reg), 32'hA6);
    check("bin_exec_cnt", 32'(n_exec - base_exec), 32'd1);
    check("bin_init_cnt", 32'(n_init - base_init), 32'd0);
    check("bin_state",    32'(state),   32'd0);

    // Unary op: B forced to zero, execute after the second press
    snap();
    press(8'h04, 2);
    press(8'h05, 2);
    check("un_exec_cnt",  32'(n_exec - base_exec), 32'd1);
    check("un_opa",       32'(opa_reg), 32'h05);
    check("un_opb",       32'(opb_reg), 32'h00);
    check("un_state",     32'(state),   32'd0);

    // Multiply entry
    snap();
    press(8'h0C, 2);
    press(8'h66, 2);
    press(8'h2D, 2);
    check("mul_exec_cnt", 32'(n_exec - base_exec), 32'd1);
    check("mul_init_cnt", 32'(n_init - base_init), 32'd1);
    check("mul_state",    32'(state),    32'd4);
    check("mul_step0",    32'(step_cnt), 32'd0);
    check("mul_opa",      32'(opa_reg),  32'h66);
    check("mul_opb",      32'(opb_reg),  32'h2D);
    for (int i = 1; i <= 8; i++) begin
      press(8'(i), 2);
      check("mul_step_cnt", 32'(step_cnt), 32'(i));
      check("mul_step_num", 32'(n_step - base_step), 32'(i));
      check("mul_step_st",  32'(state), (i < 8) ? 32'd4 : 32'd0);
    end
    // A further press is an opcode entry; step count holds
    press(8'h03, 2);
    check("mul9_op",      32'(op_reg),   32'h3);
    check("mul9_state",   32'(state),    32'd1);
    check("mul9_steps",   32'(n_step - base_step), 32'd8);
    check("mul9_cnt",     32'(step_cnt), 32'd8);
    press(8'h0F, 2);
    press(8'hF0, 2);
    check("xor_state",    32'(state),    32'd0);
    check("xor_cnt_hold", 32'(step_cnt), 32'd8);
    check("xor_exec_cnt", 32'(n_exec - base_exec), 32'd2);

    // Illegal opcode
    press(8'h0E, 2);
    check("ill_err",      32'(op_err), 32'd1);
    check("ill_state",    32'(state),  32'd0);
    check("ill_op",       32'(op_reg), 32'h3);
    // Long press (200 ns), upper nibble ignored, single capture
    press(8'hA2, 10);
    check("long_op",      32'(op_reg),  32'h2);
    check("long_err",     32'(op_err),  32'd0);
    check("long_state",   32'(state),   32'd1);
    check("long_opa",     32'(opa_reg), 32'h0F);
    repeat (4) @(negedge CLOCK_50);
    check("long_state2",  32'(state),   32'd1);
    press(8'h10, 2);
    press(8'h20, 2);
    check("long_done",    32'(state),   32'd0);
    check("long_opb",     32'(opb_reg), 32'h20);

    // Reset in the middle of a multiply
    press(8'h0C, 2);
    press(8'h01, 2);
    press(8'h02, 2);
    for (int i = 0; i < 3; i++) press(8'h00, 2);
    check("mr_cnt_pre",   32'(step_cnt), 32'd3);
    check("mr_state_pre", 32'(state),    32'd4);
    do_reset();
    check("mr_state",     32'(state),    32'd0);
    check("mr_cnt",       32'(step_cnt), 32'd0);
    check("mr_op",        32'(op_reg),   32'd0);
    check("mr_opa",       32'(opa_reg),  32'd0);
    check("mr_opb",       32'(opb_reg),  32'd0);
    @(negedge CLOCK_50);
    check("mr_after_strobes", 32'({exec_pulse, mult_init, mult_step}), 32'd0);
    snap();
    press(8'h01, 2);
    check("mr_p1_state",  32'(state),    32'd1);
    press(8'h11, 2);
    press(8'h22, 2);
    check("mr_no_steps",  32'(n_step - base_step), 32'd0);
    check("mr_exec_cnt",  32'(n_exec - base_exec), 32'd1);
    check("mr_state_end", 32'(state),    32'd0);
    check("mr_cnt_end",   32'(step_cnt), 32'd0);

    // Strobe timing relationships observed over the whole run
    check("strobe_timing", 32'(n_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
